// File: rtl/style_pkg.sv
// Shared pixel types and channel slice positions for the video path.
package style_pkg;

  localparam int unsigned PIX_W = 24;

  localparam int unsigned R_MSB = 23;
  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_MSB = 15;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_MSB = 7;
  localparam int unsigned B_LSB = 0;

  typedef logic [PIX_W-1:0] pixel_t;

  // Assemble a pixel from its three 8-bit channels.
  function automatic pixel_t packPixel(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
    pixel_t p;
    p = '0;
    p[R_MSB:R_LSB] = r;
    p[G_MSB:G_LSB] = g;
    p[B_MSB:B_LSB] = b;
    return p;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage: single write port, combinational read at
// the same address that returns the pre-write contents.
module line_buffer
  import style_pkg::*;
#(
  parameter int unsigned DEPTH = 640,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wrEn,
  input  logic [AW-1:0] addr,
  input  pixel_t        wrData,
  output pixel_t        rdData_c
);

  pixel_t mem [DEPTH];

  // Write the accepted pixel; the read below still sees the old word this cycle.
  always_ff @(posedge clk) begin
    if (wrEn) mem[addr] <= wrData;
  end

  assign rdData_c = mem[addr];

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a register
// window, flagging only windows whose center is an interior pixel.
module window3x3_gen
  import style_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic   iCLK,
  input  logic   iRST_N,
  input  logic   iDVAL,
  input  logic   iSOF,
  input  pixel_t iRGB,
  output pixel_t oC0,
  output pixel_t oC1,
  output pixel_t oC2,
  output pixel_t oC3,
  output pixel_t oC4,
  output pixel_t oC5,
  output pixel_t oC6,
  output pixel_t oC7,
  output pixel_t oC8,
  output logic   oDVAL
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] curX_c;
  logic [YW-1:0] curY_c;
  logic [XW-1:0] nextX_c;
  logic [YW-1:0] nextY_c;
  logic          winValid_c;
  logic          wrEn_c;
  pixel_t        lb1Rd_c;
  pixel_t        lb2Rd_c;

  // Position of the incoming pixel (SOF forces origin) and the position after it.
  always_comb begin
    curX_c  = x;
    curY_c  = y;
    if (iSOF) begin
      curX_c = '0;
      curY_c = '0;
    end
    nextX_c = curX_c + XW'(1);
    nextY_c = curY_c;
    if (curX_c == XW'(IMG_W - 1)) begin
      nextX_c = '0;
      nextY_c = (curY_c == YW'(IMG_H - 1)) ? '0 : curY_c + YW'(1);
    end
  end

  assign winValid_c = (curX_c >= XW'(2)) && (curY_c >= YW'(2));
  assign wrEn_c     = iDVAL && iRST_N;

  // LB1 holds the previous line, LB2 the line before that.
  line_buffer #(.DEPTH(IMG_W)) uLb1 (
    .clk     (iCLK),
    .wrEn    (wrEn_c),
    .addr    (curX_c),
    .wrData  (iRGB),
    .rdData_c(lb1Rd_c)
  );

  line_buffer #(.DEPTH(IMG_W)) uLb2 (
    .clk     (iCLK),
    .wrEn    (wrEn_c),
    .addr    (curX_c),
    .wrData  (lb1Rd_c),
    .rdData_c(lb2Rd_c)
  );

  // Raster position counters, advanced once per accepted pixel.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      x <= '0;
      y <= '0;
    end else if (iDVAL) begin
      x <= nextX_c;
      y <= nextY_c;
    end
  end

  // Window registers shift left; new right column comes from LB2, LB1, input.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oC0   <= '0;
      oC1   <= '0;
      oC2   <= '0;
      oC3   <= '0;
      oC4   <= '0;
      oC5   <= '0;
      oC6   <= '0;
      oC7   <= '0;
      oC8   <= '0;
      oDVAL <= 1'b0;
    end else begin
      oDVAL <= iDVAL && winValid_c;
      if (iDVAL) begin
        oC0 <= oC1;
        oC1 <= oC2;
        oC2 <= lb2Rd_c;
        oC3 <= oC4;
        oC4 <= oC5;
        oC5 <= lb1Rd_c;
        oC6 <= oC7;
        oC7 <= oC8;
        oC8 <= iRGB;
      end
    end
  end

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen: a small 4x4 instance and a 16x12 instance, an image
// model feeding a window scoreboard, and a per-cycle valid check.
module tb_window3x3_gen;
  import style_pkg::*;

  localparam int unsigned SW = 4;
  localparam int unsigned SH = 4;
  localparam int unsigned LW = 16;
  localparam int unsigned LH = 12;

  typedef logic [8:0][23:0] win_t;
  typedef struct {
    int px;
    int py;
    bit sof;
    bit expV;
  } vec_t;

  logic   clk = 1'b0;
  logic   rstN, dvalS, dvalL, sof;
  pixel_t rgb;
  pixel_t cS [9];
  pixel_t cL [9];
  logic   vS, vL;

  always #5 clk = ~clk;

  window3x3_gen #(.IMG_W(SW), .IMG_H(SH)) dutS (
    .iCLK(clk), .iRST_N(rstN), .iDVAL(dvalS), .iSOF(sof), .iRGB(rgb),
    .oC0(cS[0]), .oC1(cS[1]), .oC2(cS[2]), .oC3(cS[3]), .oC4(cS[4]),
    .oC5(cS[5]), .oC6(cS[6]), .oC7(cS[7]), .oC8(cS[8]), .oDVAL(vS)
  );

  window3x3_gen #(.IMG_W(LW), .IMG_H(LH)) dutL (
    .iCLK(clk), .iRST_N(rstN), .iDVAL(dvalL), .iSOF(sof), .iRGB(rgb),
    .oC0(cL[0]), .oC1(cL[1]), .oC2(cL[2]), .oC3(cL[3]), .oC4(cL[4]),
    .oC5(cL[5]), .oC6(cL[6]), .oC7(cL[7]), .oC8(cL[8]), .oDVAL(vL)
  );

  int     checks = 0;
  int     errors = 0;
  win_t   expQ [$];
  win_t   gotLog [$];
  win_t   refWin [4];
  pixel_t img [0:15][0:15];
  int     mx, my, curW, curH;
  bit     sel;
  bit     monOn;
  logic   expV;

  task automatic check(input string nm, input logic [215:0] got, input logic [215:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic pixel_t pv(input int px, input int py);
    return packPixel(8'(py), 8'(px), 8'(py * curW + px));
  endfunction

  // Per-cycle valid check and window scoreboard, sampled after the edge.
  always @(posedge clk) begin
    logic v;
    logic vOther;
    win_t w;
    win_t e;
    #1;
    if (monOn) begin
      v      = sel ? vL : vS;
      vOther = sel ? vS : vL;
      for (int i = 0; i < 9; i++) w[i] = sel ? cL[i] : cS[i];
      check("oDVAL", 216'(v), 216'(expV));
      check("idle_dut_oDVAL", 216'(vOther), 216'(0));
      if (v) begin
        gotLog.push_back(w);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL window_unexpected: got %0h, expected no window", w);
        end else begin
          e = expQ.pop_front();
          check("window", w, e);
        end
      end
    end
  end

  // One cycle of stimulus; ev < 0 takes the expected valid from the image model.
  task automatic drive(input bit dv, input bit s, input pixel_t v, input int ev);
    bit   mv;
    win_t w;
    @(negedge clk);
    dvalS = dv && !sel;
    dvalL = dv && sel;
    sof   = s;
    rgb   = v;
    mv    = 1'b0;
    if (dv) begin
      if (s) begin
        mx = 0;
        my = 0;
      end
      img[my][mx] = v;
      if (mx >= 2 && my >= 2) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            w[r*3+c] = img[my-2+r][mx-2+c];
        expQ.push_back(w);
        mv = 1'b1;
      end
      if (mx == curW - 1) begin
        mx = 0;
        my = (my == curH - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    expV = (ev < 0) ? mv : ev[0];
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, -1);
  endtask

  task automatic sendFrame(input bit firstSof, input int gapMax);
    for (int py = 0; py < curH; py++)
      for (int px = 0; px < curW; px++) begin
        drive(1'b1, firstSof && px == 0 && py == 0, pv(px, py), -1);
        if (gapMax > 0) idle(int'($urandom_range(0, gapMax)));
      end
  endtask

  task automatic rstPulse();
    @(negedge clk);
    rstN  = 1'b0;
    dvalS = 1'b0;
    dvalL = 1'b0;
    sof   = 1'b0;
    expV  = 1'b0;
    mx    = 0;
    my    = 0;
    @(posedge clk);
    #2;
    for (int i = 0; i < 9; i++) begin
      check("rst_small_oC", 216'(cS[i]), 216'(0));
      check("rst_large_oC", 216'(cL[i]), 216'(0));
    end
    check("rst_small_oDVAL", 216'(vS), 216'(0));
    check("rst_large_oDVAL", 216'(vL), 216'(0));
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic matchRef(input string nm, input int base);
    for (int i = 0; i < 4; i++) check(nm, gotLog[base+i], refWin[i]);
  endtask

  initial begin
    vec_t tbl [16];
    int   base;

    for (int i = 0; i < 16; i++) begin
      tbl[i].px   = i % 4;
      tbl[i].py   = i / 4;
      tbl[i].sof  = (i == 0);
      tbl[i].expV = 1'b0;
    end
    tbl[10].expV = 1'b1;
    tbl[11].expV = 1'b1;
    tbl[14].expV = 1'b1;
    tbl[15].expV = 1'b1;

    monOn = 1'b0;
    rstN  = 1'b0;
    dvalS = 1'b0;
    dvalL = 1'b0;
    sof   = 1'b0;
    rgb   = '0;
    expV  = 1'b0;
    sel   = 1'b0;
    curW  = SW;
    curH  = SH;
    mx    = 0;
    my    = 0;
    repeat (2) @(negedge clk);
    monOn = 1'b1;
    rstPulse();

    // Small frame, continuous, table driven
    base = gotLog.size();
    for (int i = 0; i < 16; i++)
      drive(1'b1, tbl[i].sof, pv(tbl[i].px, tbl[i].py), int'(tbl[i].expV));
    idle(3);
    check("frame_count", 216'(gotLog.size() - base), 216'(4));
    if (gotLog.size() - base == 4) begin
      check("first_oC0", 216'(gotLog[base][0]), 216'(pv(0, 0)));
      check("first_oC4", 216'(gotLog[base][4]), 216'(pv(1, 1)));
      check("first_oC8", 216'(gotLog[base][8]), 216'(pv(2, 2)));
      check("last_oC8", 216'(gotLog[base+3][8]), 216'(pv(3, 3)));
      for (int i = 0; i < 4; i++) refWin[i] = gotLog[base+i];
    end else begin
      for (int i = 0; i < 4; i++) refWin[i] = '0;
    end

    // Same frame with random gaps
    base = gotLog.size();
    sendFrame(1'b1, 5);
    idle(3);
    check("gap_count", 216'(gotLog.size() - base), 216'(4));
    if (gotLog.size() - base == 4) matchRef("gap_window", base);

    // Two back-to-back frames
    base = gotLog.size();
    sendFrame(1'b1, 0);
    sendFrame(1'b1, 0);
    idle(3);
    check("b2b_count", 216'(gotLog.size() - base), 216'(8));
    if (gotLog.size() - base == 8) begin
      matchRef("b2b_frame1", base);
      matchRef("b2b_frame2", base + 4);
    end

    // SOF mid-frame at (1,2)
    base = gotLog.size();
    for (int i = 0; i < 9; i++) drive(1'b1, i == 0, pv(i % 4, i / 4), -1);
    sendFrame(1'b1, 0);
    idle(3);
    check("sof_resync_count", 216'(gotLog.size() - base), 216'(4));
    if (gotLog.size() - base == 4) matchRef("sof_resync_window", base);

    // Reset mid-frame after one window, then a frame without SOF
    for (int i = 0; i < 11; i++) drive(1'b1, i == 0, pv(i % 4, i / 4), -1);
    rstPulse();
    base = gotLog.size();
    sendFrame(1'b0, 0);
    idle(3);
    check("post_rst_count", 216'(gotLog.size() - base), 216'(4));
    if (gotLog.size() - base == 4) matchRef("post_rst_window", base);

    // Larger frame, twice; the second relies on the counters wrapping
    sel  = 1'b1;
    curW = LW;
    curH = LH;
    base = gotLog.size();
    sendFrame(1'b1, 0);
    sendFrame(1'b0, 0);
    idle(3);
    check("large_count", 216'(gotLog.size() - base), 216'(2 * (LW - 2) * (LH - 2)));
    if (gotLog.size() > base) begin
      check("large_last_oC8", 216'(gotLog[gotLog.size()-1][8]), 216'(pv(LW - 1, LH - 1)));
      check("large_last_oC4", 216'(gotLog[gotLog.size()-1][4]), 216'(pv(LW - 2, LH - 2)));
    end
    check("queue_drained", 216'(expQ.size()), 216'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
